// File: rtl/clkdiv_rst_seq.sv
// clkdiv_rst_seq
//   Clock divider and reset sequencer for the SGBM datapath. Produces NUM_CH
//   divided clocks from clkin, each with a one-cycle enable pulse on the
//   cycle its clock rises. It then releases a per-channel active-low reset,
//   aligned to that channel's enable, after an RST_DLY-cycle power-on delay.
//
//   Optional feature macro: CLKDIV_RUNTIME_CFG_EN
//     defined   : div_cfg/div_load reprogram each channel's divisor. The new
//                 value goes through a shadow register and takes effect at
//                 the next counter wrap.
//     undefined : div_cfg/div_load are ignored and every channel is fixed at
//                 DEF_DIV.
//
//   Ports
//     clkin    in   system clock, rising edge
//     rst0     in   async active-high reset
//     div_cfg  in   per-channel divisor, channel i at [i*DIV_W +: DIV_W]
//     div_load in   per-channel load strobe for div_cfg
//     soft_rst in   one-cycle request to re-run the reset sequence
//     clkout   out  divided clocks (registered)
//     clken    out  one-cycle pulse on the cycle clkout[i] rises
//     restn    out  per-channel active-low reset
//     ready    out  all channels out of reset and sequencer in RUN
module clkdiv_rst_seq #(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 4,
  parameter int RST_DLY = 200,
  parameter int RST_W   = 8
) (
  input  logic                      clkin,
  input  logic                      rst0,
  input  logic [NUM_CH*DIV_W-1:0]   div_cfg,
  input  logic [NUM_CH-1:0]         div_load,
  input  logic                      soft_rst,
  output logic [NUM_CH-1:0]         clkout,
  output logic [NUM_CH-1:0]         clken,
  output logic [NUM_CH-1:0]         restn,
  output logic                      ready
);

  typedef enum logic [1:0] {HOLD, COUNT, RELEASE, RUN} state_t;

  localparam logic [DIV_W-1:0] DEF   = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
  localparam logic [RST_W-1:0] DLY_L = RST_W'(RST_DLY - 1);

  state_t            state, state_nxt;
  logic [RST_W-1:0]  dly;
  logic [NUM_CH-1:0] wrap;
  logic              run, rel_clr;

  assign run     = (state != HOLD);
  // soft_rst only tears down an established or in-progress release
  assign rel_clr = soft_rst && ((state == RELEASE) || (state == RUN));
  assign ready   = (state == RUN) && (&restn);

  always_ff @(posedge clkin or posedge rst0)
    if (rst0) state <= HOLD;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      HOLD:    state_nxt = COUNT;
      COUNT:   if (!soft_rst && dly == DLY_L) state_nxt = RELEASE;
      RELEASE: if (soft_rst) state_nxt = COUNT;
               else if (&restn) state_nxt = RUN;
      RUN:     if (soft_rst) state_nxt = COUNT;
      default: state_nxt = HOLD;
    endcase
  end

  // Delay counter only advances while in COUNT; anything else parks it at 0
  // so re-entry into COUNT always starts from zero.
  always_ff @(posedge clkin or posedge rst0)
    if (rst0)                              dly <= '0;
    else if (state != COUNT || soft_rst)   dly <= '0;
    else                                   dly <= dly + 1'b1;

  // wrap[i] is the cycle before clken[i] goes high, so restn[i] rises
  // together with clken[i].
  always_ff @(posedge clkin or posedge rst0)
    if (rst0)                   restn <= '0;
    else if (rel_clr)           restn <= '0;
    else if (state == RELEASE)  restn <= restn | wrap;

`ifndef CLKDIV_RUNTIME_CFG_EN
  logic unused_cfg;
  assign unused_cfg = ^{div_cfg, div_load};
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] act, n_eff, half, cnt, cnt_nxt;

    assign n_eff   = (act < TWO) ? TWO : act;
    assign half    = n_eff >> 1;
    assign wrap[i] = run && (cnt == n_eff - 1'b1);
    assign cnt_nxt = wrap[i] ? '0 : cnt + 1'b1;

`ifdef CLKDIV_RUNTIME_CFG_EN
    logic [DIV_W-1:0] shadow;
    logic             pend;

    // The shadow is swapped in at the wrap using its pre-edge value, so a
    // load coinciding with a wrap lands on the following wrap instead.
    always_ff @(posedge clkin or posedge rst0)
      if (rst0) begin
        act    <= DEF;
        shadow <= DEF;
        pend   <= 1'b0;
      end else begin
        if (wrap[i] && pend) act <= shadow;
        if (div_load[i]) begin
          shadow <= div_cfg[i*DIV_W +: DIV_W];
          pend   <= 1'b1;
        end else if (wrap[i]) begin
          pend   <= 1'b0;
        end
      end
`else
    assign act = DEF;
`endif

    // clkout rises only at a wrap and falls at the half point, so the first
    // period after HOLD is a clean low phase instead of a runt high.
    always_ff @(posedge clkin or posedge rst0)
      if (rst0) begin
        cnt       <= '0;
        clkout[i] <= 1'b0;
        clken[i]  <= 1'b0;
      end else begin
        clken[i] <= wrap[i];
        if (run) begin
          cnt <= cnt_nxt;
          if (wrap[i])               clkout[i] <= 1'b1;
          else if (cnt_nxt == half)  clkout[i] <= 1'b0;
        end
      end
  end

endmodule

// File: doc/clkdiv_rst_seq.md
Name: clkdiv_rst_seq

Overview:
- Parametrised clock-divider and reset sequencer for the SGBM datapath.
- Derives NUM_CH divided clocks from clkin, each with its own divisor and a matching one-cycle clock-enable pulse.
- Releases a per-channel active-low reset after a programmable power-on delay, aligned to each channel's clock.
- Sits at the top of the design, between the board clock/reset and every SGBM processing domain.

Parameters:
- NUM_CH, 2: number of divided-clock channels (1..8).
- DIV_W, 8: width of each channel divisor.
- DEF_DIV, 4: divisor used after rst0 and whenever runtime update is compiled out.
- RST_DLY, 200: clkin cycles between reset exit (or soft_rst) and the start of reset release.
- RST_W, 8: width of the delay counter; must hold RST_DLY.

Ports:
- clkin  in  1  system clock; all logic on its rising edge.
- rst0  in  1  asynchronous, active-high reset.
- div_cfg  in  NUM_CH*DIV_W  per-channel divisor; channel i in bits [i*DIV_W +: DIV_W].
- div_load  in  NUM_CH  per-channel pulse: capture div_cfg slice into the shadow register.
- soft_rst  in  1  synchronous one-cycle request to re-run the reset sequence.
- clkout  out  NUM_CH  divided clocks, registered.
- clken  out  NUM_CH  one-clkin-cycle pulse on the cycle clkout[i] rises.
- restn  out  NUM_CH  active-low reset per channel (0 = held in reset).
- ready  out  1  high when every restn is 1 and the FSM is in RUN.

Behaviour:
- rst0 asserted (async) sets the following:
  - clkout=0, clken=0, restn=0, ready=0.
  - All channel counters=0, active and shadow divisors=DEF_DIV, no load pending, FSM=HOLD.
- Divisor rules:
  - Effective N = active divisor, clamped to 2 when the value is 0 or 1.
  - clkout[i] is high for floor(N/2) clkin cycles and low for N-floor(N/2) cycles; N=4 gives 2 high, 2 low.
  - Counter runs 0..N-1 and wraps.
  - clkout rises when the counter wraps to 0; clken[i] is asserted in that same cycle.
- Divisor update:
  - div_load[i] copies the slice into shadow and sets pending[i].
  - The shadow value becomes active only at the channel's next counter wrap, so no runt pulses occur.
  - A second load before that wrap overwrites the shadow; only the latest value applies.
  - div_load in the same cycle as the wrap: the new value is taken at the following wrap, not this one.
- FSM states:
  - HOLD: entered on rst0; moves to COUNT on the first clkin edge after rst0 deasserts.
  - COUNT: delay counter increments from 0; after RST_DLY cycles (counter == RST_DLY-1) moves to RELEASE.
  - RELEASE: each channel sets restn[i]=1 at its own next clken[i]. Channels release independently. When all are released, moves to RUN and ready=1 in the next cycle.
  - RUN: steady state.
- soft_rst:
  - In RUN or RELEASE: all restn=0, ready=0, delay counter cleared, go to COUNT. Divided clocks keep running and active divisors are retained.
  - In COUNT: restarts the count from 0.
  - Ignored in HOLD.
- Simultaneous events: rst0 overrides everything; soft_rst overrides a release in the same cycle.
- Divided clocks run in all states except HOLD.

Optional Feature:
- Macro CLKDIV_RUNTIME_CFG_EN.
- Defined: div_cfg/div_load reprogramming works as described above.
- Undefined: div_cfg and div_load remain as ports but are ignored. All channels use DEF_DIV permanently and no shadow/pending logic is built.

Test Plan:
- Basic reset sequence: rst0 high 10 cycles then low, NUM_CH=2, defaults.
  - clkout period 4 (2 high/2 low).
  - Delay count lasts 200 cycles; each restn rises at its channel's first clken after that.
  - ready rises 1 cycle after the last restn.
- Runtime divisor change: div_cfg ch0=6, div_load=01 mid-period.
  - ch0 finishes its current 4-cycle period, then runs 3 high/3 low.
  - ch1 is unaffected.
- Odd and degenerate divisors:
  - Load 5: 2 high/3 low.
  - Load 0 and load 1: each behaves as divide-by-2 (1 high/1 low).
- Double load before wrap: load 8 then 3 in consecutive cycles → only 3 takes effect (1 high/2 low).
- soft_rst in RUN: restn=00 and ready=0 next cycle; clocks keep toggling; after 200 cycles restn re-releases on clken.
- rst0 asserted during RELEASE with ch0 released and ch1 not: outputs clear immediately (asynchronous); divisors return to 4.
